// File: rtl/gat_feat_drain.sv
// ============================================================================
// gat_feat_drain: streams a finished GAT layer result out of the feature BRAM
// as an AXI-Stream frame, with credit-based prefetch into a small skid FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gat_feat_drain #(
    parameter int NEW_FEATURE_WIDTH = 32,
    parameter int NUM_SUBGRAPHS     = 2708,
    parameter int NUM_FEATURE_OUT   = 16,
    parameter int RD_LATENCY        = 2,
    localparam int NEW_FEATURE_DEPTH  = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
    localparam int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    localparam int FIFO_DEPTH         = RD_LATENCY + 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            drain_start,
    input  logic                            gat_ready,
    output logic [NEW_FEATURE_ADDR_W+1:0]   feat_bram_addrb,
    input  logic [NEW_FEATURE_WIDTH-1:0]    feat_bram_dout,
    output logic [NEW_FEATURE_WIDTH-1:0]    m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic                            m_tuser,
    output logic                            drain_busy,
    output logic                            drain_done,
    output logic [NEW_FEATURE_ADDR_W:0]     drain_word_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1) + 1;
    localparam int FEAT_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
    localparam int ENT_W  = NEW_FEATURE_WIDTH + 2;

    localparam logic [CNT_W-1:0]              C_FIFO_DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [NEW_FEATURE_ADDR_W-1:0] C_IDX_LAST   = NEW_FEATURE_ADDR_W'(NEW_FEATURE_DEPTH - 1);
    localparam logic [FEAT_W-1:0]             C_FEAT_LAST  = FEAT_W'(NUM_FEATURE_OUT - 1);
    localparam logic [PTR_W-1:0]              C_PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RDY = 3'd1,
        READ     = 3'd2,
        FLUSH    = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t                          r_state, w_next;
    logic [NEW_FEATURE_ADDR_W-1:0]   r_idx;
    logic [FEAT_W-1:0]               r_feat;
    logic [NEW_FEATURE_ADDR_W+1:0]   r_addr;
    logic [RD_LATENCY-1:0]           r_vld, r_tag_last, r_tag_user;
    logic [ENT_W-1:0]                r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]                r_wptr, r_rptr;
    logic [CNT_W-1:0]                r_fcnt;
    logic [NEW_FEATURE_ADDR_W:0]     r_wcnt;

    logic                            w_start_acc, w_issue, w_idx_last, w_feat_last;
    logic                            w_push, w_pop, w_fvalid;
    logic [CNT_W-1:0]                w_inflight;
    logic [ENT_W-1:0]                w_head;

    assign w_start_acc = (r_state == IDLE) && drain_start;
    assign w_idx_last  = (r_idx == C_IDX_LAST);
    assign w_feat_last = (r_feat == C_FEAT_LAST);

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < RD_LATENCY; k++) begin
            w_inflight = w_inflight + CNT_W'(r_vld[k]);
        end
    end

    // Reads already in flight reserve a FIFO slot, so the FIFO can never overflow.
    assign w_issue = (r_state == READ) && ((r_fcnt + w_inflight) < C_FIFO_DEPTH);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (drain_start) w_next = WAIT_RDY;
            WAIT_RDY: if (gat_ready) w_next = READ;
            READ:     if (w_issue && w_idx_last) w_next = FLUSH;
            FLUSH:    if ((w_inflight == '0) && (r_fcnt == '0)) w_next = DONE;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_feat     <= '0;
            r_addr     <= '0;
            r_vld      <= '0;
            r_tag_last <= '0;
            r_tag_user <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_acc) begin
                r_idx  <= '0;
                r_feat <= '0;
            end else if (w_issue) begin
                r_addr <= {r_idx, 2'b00};
                if (!w_idx_last) r_idx <= r_idx + NEW_FEATURE_ADDR_W'(1);
                r_feat <= w_feat_last ? '0 : r_feat + FEAT_W'(1);
            end
            r_vld[0]      <= w_issue;
            r_tag_last[0] <= w_issue && w_feat_last;
            r_tag_user[0] <= w_issue && w_idx_last;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_vld[k]      <= r_vld[k-1];
                r_tag_last[k] <= r_tag_last[k-1];
                r_tag_user[k] <= r_tag_user[k-1];
            end
        end
    end

    // Address is presented combinationally on the issue cycle so data lands RD_LATENCY cycles later.
    assign feat_bram_addrb = w_issue ? {r_idx, 2'b00} : r_addr;

    assign w_push   = r_vld[RD_LATENCY-1];
    assign w_fvalid = (r_fcnt != '0);
    assign w_pop    = w_fvalid && m_tready;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_tag_user[RD_LATENCY-1], r_tag_last[RD_LATENCY-1], feat_bram_dout};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fcnt <= '0;
            r_wcnt <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == C_PTR_LAST) ? '0 : r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= (r_rptr == C_PTR_LAST) ? '0 : r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
                2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
                default: r_fcnt <= r_fcnt;
            endcase
            if (w_start_acc) r_wcnt <= '0;
            else if (w_pop)  r_wcnt <= r_wcnt + (NEW_FEATURE_ADDR_W+1)'(1);
        end
    end

    assign w_head         = r_mem[r_rptr];
    assign m_tvalid       = w_fvalid;
    assign m_tdata        = w_fvalid ? w_head[NEW_FEATURE_WIDTH-1:0] : '0;
    assign m_tlast        = w_fvalid && w_head[NEW_FEATURE_WIDTH];
    assign m_tuser        = w_fvalid && w_head[NEW_FEATURE_WIDTH+1];
    assign drain_busy     = (r_state != IDLE);
    assign drain_done     = (r_state == DONE);
    assign drain_word_cnt = r_wcnt;

endmodule

`default_nettype wire

// File: tb/tb_gat_feat_drain.sv
// ============================================================================
// tb_gat_feat_drain: directed self-checking bench for gat_feat_drain
// (3 nodes x 4 features, RD_LATENCY=2, BRAM word[i] = i + 0x100).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gat_feat_drain;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drain_start = 1'b0;
    logic        gat_ready = 1'b0;
    logic        m_tready = 1'b1;
    logic [5:0]  feat_bram_addrb;
    logic [31:0] feat_bram_dout = '0;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tuser, drain_busy, drain_done;
    logic [4:0]  drain_word_cnt;

    gat_feat_drain #(
        .NEW_FEATURE_WIDTH(32),
        .NUM_SUBGRAPHS(3),
        .NUM_FEATURE_OUT(4),
        .RD_LATENCY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .drain_start(drain_start),
        .gat_ready(gat_ready),
        .feat_bram_addrb(feat_bram_addrb),
        .feat_bram_dout(feat_bram_dout),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast(m_tlast),
        .m_tuser(m_tuser),
        .drain_busy(drain_busy),
        .drain_done(drain_done),
        .drain_word_cnt(drain_word_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tr_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Two-cycle BRAM model: address seen in cycle k, data valid in cycle k+2.
    logic [31:0] r_p1 = '0;
    always @(posedge clk) begin
        r_p1           <= 32'h100 + 32'(feat_bram_addrb >> 2);
        feat_bram_dout <= r_p1;
    end

    // tready modes: 0 = always 1, 1 = 1,0,0,1 repeating, 2 = always 0.
    always @(posedge clk) begin
        #1;
        case (tr_mode)
            1:       m_tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       m_tready = 1'b0;
            default: m_tready = 1'b1;
        endcase
    end

    logic [31:0] q_data[$];
    bit          q_last[$];
    bit          q_user[$];
    int          q_cyc[$];
    int          done_cnt = 0;
    int          stab_viol = 0;
    int          addr_nz = 0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    always @(negedge clk) begin
        if (m_tvalid && m_tready) begin
            q_data.push_back(m_tdata);
            q_last.push_back(m_tlast);
            q_user.push_back(m_tuser);
            q_cyc.push_back(cyc);
        end
        if (drain_done) done_cnt++;
        if (prev_stall && m_tvalid && (m_tdata !== prev_data)) stab_viol++;
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        if (feat_bram_addrb != 6'd0) addr_nz++;
    end

    task automatic pulse_start(output int t0);
        @(posedge clk); #1;
        drain_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        drain_start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            @(negedge clk);
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({m_tvalid, m_tlast, m_tuser, drain_busy, drain_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 00000", {m_tvalid, m_tlast, m_tuser, drain_busy, drain_done});
        end
        checks++;
        if (m_tdata !== 32'h0 || feat_bram_addrb !== 6'h0 || drain_word_cnt !== 5'd0) begin
            errors++;
            $display("FAIL reset_values got tdata=%h addrb=%h cnt=%0d want 0/0/0", m_tdata, feat_bram_addrb, drain_word_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_wait_ready();
        int t0, tr, base, dbase, abase;
        bit ok;
        base = q_data.size(); dbase = done_cnt; abase = addr_nz;
        gat_ready = 1'b0;
        pulse_start(t0);
        repeat (20) @(negedge clk);
        checks++;
        if (addr_nz != abase || q_data.size() != base || drain_busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle got addr_nz=%0d words=%0d busy=%b want 0/0/1", addr_nz - abase, q_data.size() - base, drain_busy);
        end
        @(posedge clk); #1;
        gat_ready = 1'b1;
        tr = cyc;
        wait_done(dbase, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_timeout got no done want done"); end
        checks++;
        if (q_data.size() - base != 12) begin
            errors++;
            $display("FAIL wait_count got %0d want 12", q_data.size() - base);
        end
        for (int k = 0; k < 12 && base + k < q_data.size(); k++) begin
            checks++;
            if (q_data[base+k] !== 32'h100 + k || q_last[base+k] !== ((k % 4) == 3) || q_user[base+k] !== (k == 11)
                || q_cyc[base+k] !== tr + 4 + k) begin
                errors++;
                $display("FAIL wait_word%0d got d=%h l=%b u=%b cyc=%0d want d=%h l=%b u=%b cyc=%0d", k,
                         q_data[base+k], q_last[base+k], q_user[base+k], q_cyc[base+k],
                         32'h100 + k, ((k % 4) == 3), (k == 11), tr + 4 + k);
            end
        end
    endtask

    task automatic test_basic();
        int t0, base, dbase;
        bit ok;
        base = q_data.size(); dbase = done_cnt;
        pulse_start(t0);
        wait_done(dbase, 200, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || done_cnt - dbase != 1) begin
            errors++;
            $display("FAIL basic_done got %0d pulses want 1", done_cnt - dbase);
        end
        checks++;
        if (drain_word_cnt !== 5'd12 || drain_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_cnt got cnt=%0d busy=%b want 12/0", drain_word_cnt, drain_busy);
        end
        checks++;
        if (q_data.size() - base != 12) begin
            errors++;
            $display("FAIL basic_count got %0d want 12", q_data.size() - base);
        end
        for (int k = 0; k < 12 && base + k < q_data.size(); k++) begin
            checks++;
            if (q_data[base+k] !== 32'h100 + k || q_last[base+k] !== ((k % 4) == 3) || q_user[base+k] !== (k == 11)
                || q_cyc[base+k] !== t0 + 5 + k) begin
                errors++;
                $display("FAIL basic_word%0d got d=%h l=%b u=%b cyc=%0d want d=%h l=%b u=%b cyc=%0d", k,
                         q_data[base+k], q_last[base+k], q_user[base+k], q_cyc[base+k],
                         32'h100 + k, ((k % 4) == 3), (k == 11), t0 + 5 + k);
            end
        end
    endtask

    task automatic test_tready_toggle();
        int t0, base, dbase, sbase;
        bit ok;
        base = q_data.size(); dbase = done_cnt; sbase = stab_viol;
        tr_mode = 1;
        pulse_start(t0);
        wait_done(dbase, 300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL toggle_timeout got no done want done"); end
        checks++;
        if (stab_viol != sbase) begin
            errors++;
            $display("FAIL toggle_stable got %0d changes want 0", stab_viol - sbase);
        end
        checks++;
        if (q_data.size() - base != 12 || drain_word_cnt !== 5'd12) begin
            errors++;
            $display("FAIL toggle_count got %0d/%0d want 12", q_data.size() - base, drain_word_cnt);
        end
        for (int k = 0; k < 12 && base + k < q_data.size(); k++) begin
            checks++;
            if (q_data[base+k] !== 32'h100 + k || q_last[base+k] !== ((k % 4) == 3) || q_user[base+k] !== (k == 11)) begin
                errors++;
                $display("FAIL toggle_word%0d got d=%h l=%b u=%b want d=%h l=%b u=%b", k,
                         q_data[base+k], q_last[base+k], q_user[base+k], 32'h100 + k, ((k % 4) == 3), (k == 11));
            end
        end
        tr_mode = 0;
    endtask

    task automatic test_restart_ignored();
        int t0, t1, base, dbase;
        bit ok;
        base = q_data.size(); dbase = done_cnt;
        pulse_start(t0);
        repeat (8) @(negedge clk);
        pulse_start(t1);
        wait_done(dbase, 200, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (!ok || done_cnt - dbase != 1 || drain_busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_done got %0d pulses busy=%b want 1/0", done_cnt - dbase, drain_busy);
        end
        checks++;
        if (q_data.size() - base != 12 || drain_word_cnt !== 5'd12) begin
            errors++;
            $display("FAIL restart_count got %0d/%0d want 12", q_data.size() - base, drain_word_cnt);
        end
        for (int k = 0; k < 12 && base + k < q_data.size(); k++) begin
            checks++;
            if (q_data[base+k] !== 32'h100 + k) begin
                errors++;
                $display("FAIL restart_word%0d got %h want %h", k, q_data[base+k], 32'h100 + k);
            end
        end
    endtask

    task automatic test_backpressure();
        int t0, base, dbase, sbase;
        bit ok;
        tr_mode = 2;
        repeat (2) @(negedge clk);
        base = q_data.size(); dbase = done_cnt; sbase = stab_viol;
        pulse_start(t0);
        repeat (50) @(negedge clk);
        checks++;
        if (feat_bram_addrb !== 6'h0C) begin
            errors++;
            $display("FAIL bp_addr got %h want 0c", feat_bram_addrb);
        end
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h100 || stab_viol != sbase || q_data.size() != base) begin
            errors++;
            $display("FAIL bp_hold got valid=%b data=%h changes=%0d want 1/100/0", m_tvalid, m_tdata, stab_viol - sbase);
        end
        tr_mode = 0;
        wait_done(dbase, 200, ok);
        checks++;
        if (!ok || q_data.size() - base != 12) begin
            errors++;
            $display("FAIL bp_count got %0d want 12", q_data.size() - base);
        end
        for (int k = 0; k < 12 && base + k < q_data.size(); k++) begin
            checks++;
            if (q_data[base+k] !== 32'h100 + k || q_last[base+k] !== ((k % 4) == 3) || q_user[base+k] !== (k == 11)) begin
                errors++;
                $display("FAIL bp_word%0d got d=%h l=%b u=%b want d=%h", k,
                         q_data[base+k], q_last[base+k], q_user[base+k], 32'h100 + k);
            end
        end
    endtask

    task automatic test_mid_reset();
        int t0, base, dbase;
        bit ok, seen;
        base = q_data.size();
        seen = 1'b0;
        pulse_start(t0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (q_data.size() - base >= 5) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL mrst_wait got %0d words want 5", q_data.size() - base); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_tvalid, m_tlast, m_tuser, drain_busy, drain_done} !== 5'b0 || m_tdata !== 32'h0
            || feat_bram_addrb !== 6'h0 || drain_word_cnt !== 5'd0) begin
            errors++;
            $display("FAIL mrst_values got flags=%b tdata=%h addrb=%h cnt=%0d want 0", 
                     {m_tvalid, m_tlast, m_tuser, drain_busy, drain_done}, m_tdata, feat_bram_addrb, drain_word_cnt);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        base = q_data.size();
        repeat (15) @(negedge clk);
        checks++;
        if (drain_busy !== 1'b0 || q_data.size() != base) begin
            errors++;
            $display("FAIL mrst_noresume got busy=%b words=%0d want 0/0", drain_busy, q_data.size() - base);
        end
        dbase = done_cnt;
        pulse_start(t0);
        wait_done(dbase, 200, ok);
        checks++;
        if (!ok || q_data.size() - base != 12 || drain_word_cnt !== 5'd12) begin
            errors++;
            $display("FAIL mrst_count got %0d/%0d want 12", q_data.size() - base, drain_word_cnt);
        end
        for (int k = 0; k < 12 && base + k < q_data.size(); k++) begin
            checks++;
            if (q_data[base+k] !== 32'h100 + k || q_last[base+k] !== ((k % 4) == 3) || q_user[base+k] !== (k == 11)) begin
                errors++;
                $display("FAIL mrst_word%0d got d=%h l=%b u=%b want d=%h", k,
                         q_data[base+k], q_last[base+k], q_user[base+k], 32'h100 + k);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wait_ready();
        test_basic();
        test_tready_toggle();
        test_restart_ignored();
        test_backpressure();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gat_feat_drain.md
GAT_FEAT_DRAIN -- requirements
Module: gat_feat_drain

Interface
REQ-001 SHALL have parameter NEW_FEATURE_WIDTH, default 32: width of one output feature word.
REQ-002 SHALL have parameter NUM_SUBGRAPHS, default 2708: number of nodes whose features are drained.
REQ-003 SHALL have parameter NUM_FEATURE_OUT, default 16: number of feature words per node.
REQ-004 SHALL have parameter RD_LATENCY, default 2, legal values 1..3: feature BRAM port-B read latency in cycles.
REQ-005 SHALL have local parameters NEW_FEATURE_DEPTH = NUM_SUBGRAPHS*NUM_FEATURE_OUT, NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH) and FIFO_DEPTH = RD_LATENCY+2.
REQ-006 SHALL have the following ports, one clock and an asynchronous active-high reset:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- drain_start  in  1  single-cycle request to drain one result frame.
- gat_ready  in  1  level; high when the feature BRAM holds a complete layer result.
- feat_bram_addrb  out  NEW_FEATURE_ADDR_W+2  byte address to the feature BRAM, word index << 2, bits [1:0] = 0.
- feat_bram_dout  in  NEW_FEATURE_WIDTH  read data, valid RD_LATENCY cycles after the address.
- m_tdata  out  NEW_FEATURE_WIDTH  stream data.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tlast  out  1  high on the last feature word of each node.
- m_tuser  out  1  high on the last word of the frame only.
- drain_busy  out  1  high from an accepted start until done.
- drain_done  out  1  one-cycle pulse after the final word handshake.
- drain_word_cnt  out  NEW_FEATURE_ADDR_W+1  count of words handed off in the current frame.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT_RDY, READ, FLUSH and DONE.
REQ-008 IDLE: on drain_start go to WAIT_RDY; when not in IDLE, drain_start SHALL be ignored.
REQ-009 WAIT_RDY: SHALL go to READ on the first cycle gat_ready=1; a gat_ready drop after leaving WAIT_RDY SHALL be ignored.
REQ-010 READ: SHALL issue one read per cycle when (fifo_count + inflight) < FIFO_DEPTH; the word index runs 0..NEW_FEATURE_DEPTH-1 and SHALL never wrap.
REQ-011 After issuing index NEW_FEATURE_DEPTH-1, SHALL go to FLUSH; FLUSH SHALL go to DONE when inflight=0, fifo empty and the final word has been handed off.
REQ-012 DONE: SHALL assert drain_done for exactly one cycle, then return to IDLE.
REQ-013 SHALL track in-flight reads with an RD_LATENCY-deep valid shift register; each returning word SHALL be pushed into the FIFO.
REQ-014 Credit rule SHALL guarantee no FIFO overflow under any m_tready pattern.
REQ-015 FIFO SHALL support push and pop in the same cycle, with the count unchanged.
REQ-016 m_tvalid SHALL equal FIFO not-empty; m_tdata SHALL be the FIFO head and SHALL stay stable while m_tvalid=1 and m_tready=0.
REQ-017 Tags SHALL travel with each word:
- m_tlast = ((index mod NUM_FEATURE_OUT) == NUM_FEATURE_OUT-1).
- m_tuser = (index == NEW_FEATURE_DEPTH-1).
REQ-018 drain_word_cnt SHALL increment on each m_tvalid&m_tready, SHALL clear on an accepted drain_start, and SHALL hold its final value after DONE.
REQ-019 feat_bram_addrb SHALL hold the last issued address when no read is issued.
REQ-020 With m_tready held at 1, throughput SHALL be one word per cycle, and the first m_tvalid SHALL appear RD_LATENCY+1 cycles after entering READ.

Reset
REQ-021 Asserting rst, including mid-frame, SHALL immediately set the FSM to IDLE and clear the FIFO, the in-flight tracker and all counters.
REQ-022 Reset values: feat_bram_addrb=0, m_tdata=0, m_tvalid=0, m_tlast=0, m_tuser=0, drain_busy=0, drain_done=0, drain_word_cnt=0.
REQ-023 After rst deasserts, the block SHALL need a new drain_start; partial frames SHALL NOT resume.

Verification (NUM_SUBGRAPHS=3, NUM_FEATURE_OUT=4, RD_LATENCY=2, BRAM word[i]=i+0x100)
REQ-024 Start with gat_ready=1 and m_tready=1 -> 12 words 0x100..0x10B on consecutive cycles; m_tlast on 0x103, 0x107 and 0x10B; m_tuser on 0x10B only; drain_done pulses once; drain_word_cnt=12.
REQ-025 Start with gat_ready=0 for 20 cycles, then 1 -> no reads and addrb=0 during the wait; after gat_ready rises the stream is identical to REQ-024.
REQ-026 m_tready toggling 1,0,0,1 repeating -> every word 0x100..0x10B delivered exactly once, in order, with no loss or duplication, and FIFO count never above 4.
REQ-027 rst pulsed after the 5th handshake -> all outputs at reset values the next cycle; a new start yields a full 0x100..0x10B frame.
REQ-028 drain_start re-pulsed mid-frame -> ignored, with a single 12-word frame and one drain_done.
REQ-029 m_tready=0 for 50 cycles after start -> exactly 4 reads issued, addrb stops at 0x0C, and m_tdata holds 0x100 stable.
